// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the issue-side hazard logic.
// Holds the register-file constants, default result latencies and the
// latency-class encoding used by the decoder, scoreboard and forwarding unit.
package reg_scoreboard_pkg;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned MUL_LAT_DEFAULT  = 4;
  localparam int unsigned LOAD_LAT_DEFAULT = 1;

  // Latency class of an instruction's result.
  typedef enum logic [1:0] {
    LatAlu   = 2'd0,
    LatLoad  = 2'd1,
    LatMulti = 2'd2
  } lat_sel_e;

  // Multi-cycle takes priority over load when both flags are set.
  function automatic lat_sel_e lat_sel(input logic multi_cycle, input logic mem_read);
    if (multi_cycle) begin
      return LatMulti;
    end else if (mem_read) begin
      return LatLoad;
    end
    return LatAlu;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: load / saturating-decrement counter.
// Every cycle the value steps down by one until it reaches zero; a load
// takes precedence over the decrement in the same cycle.
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset, clears the count
//   load_i     - load load_val_i this cycle
//   load_val_i - value to load
//   cnt_o      - current count
module sb_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side hazard unit for the 5-stage pipeline.
// Tracks, per architectural register, the cycles left until an in-flight
// result becomes forwardable, and stalls the ID instruction on load-use,
// multi-cycle RAW/WAW, or a busy multi-cycle unit.
//   clk_i / rst_i        - clock, asynchronous active-low reset
//   ID_*_i               - decoded fields of the instruction in ID
//   Flush_i              - ID instruction is squashed this cycle
//   Stall_o              - hold the ID instruction
//   PCWrite_o            - PC write enable (~Stall_o)
//   IF_ID_Write_o        - IF/ID write enable (~Stall_o)
//   ID_EX_Bubble_o       - insert a NOP into ID/EX
//   MDU_Busy_o           - multi-cycle unit occupied
//   Pending_o            - bit r set while register r has a pending result
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEFAULT,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_valid_i,
  input  logic [4:0]  ID_RSaddr_i,
  input  logic [4:0]  ID_RTaddr_i,
  input  logic [4:0]  ID_RDaddr_i,
  input  logic        ID_RegWrite_i,
  input  logic        ID_MemRead_i,
  input  logic        ID_MultiCycle_i,
  input  logic        Flush_i,
  output logic        Stall_o,
  output logic        PCWrite_o,
  output logic        IF_ID_Write_o,
  output logic        ID_EX_Bubble_o,
  output logic        MDU_Busy_o,
  output logic [31:0] Pending_o
);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] mdu_cnt;
  logic [CNT_W-1:0] lat_val;
  logic             raw, waw, structural, stall, issue;
  logic             set_en;

  // r0 has no storage; a constant zero keeps lookups uniform.
  assign cnt[0] = '0;

  always_comb begin
    lat_val = '0;
    unique case (lat_sel(ID_MultiCycle_i, ID_MemRead_i))
      LatMulti: lat_val = CNT_W'(MUL_LAT);
      LatLoad:  lat_val = CNT_W'(LOAD_LAT);
      default:  lat_val = '0;
    endcase

    raw = ((ID_RSaddr_i != REG_ZERO) && (cnt[ID_RSaddr_i] != '0)) ||
          ((ID_RTaddr_i != REG_ZERO) && (cnt[ID_RTaddr_i] != '0));
    // A newer result must not become forwardable before an older one to the same rd.
    waw = ID_RegWrite_i && (ID_RDaddr_i != REG_ZERO) && (cnt[ID_RDaddr_i] > lat_val);
    // Back-to-back multi-cycle issue only in the unit's final busy cycle.
    structural = ID_MultiCycle_i && (mdu_cnt > CNT_W'(1));

    stall  = ID_valid_i && !Flush_i && (raw || waw || structural);
    issue  = ID_valid_i && !Flush_i && !stall;
    set_en = issue && ID_RegWrite_i && (lat_val != '0);
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg_cnt
    logic load;
    assign load = set_en && (ID_RDaddr_i == 5'(r));

    sb_counter #(
      .CntW (CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_i),
      .load_i     (load),
      .load_val_i (lat_val),
      .cnt_o      (cnt[r])
    );
  end

  sb_counter #(
    .CntW (CNT_W)
  ) u_mdu_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_i),
    .load_i     (issue && ID_MultiCycle_i),
    .load_val_i (CNT_W'(MUL_LAT)),
    .cnt_o      (mdu_cnt)
  );

  always_comb begin
    Pending_o = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      Pending_o[r] = (cnt[r] != '0);
    end
  end

  assign Stall_o        = stall;
  assign PCWrite_o      = ~stall;
  assign IF_ID_Write_o  = ~stall;
  assign ID_EX_Bubble_o = stall | Flush_i;
  assign MDU_Busy_o     = (mdu_cnt != '0);

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid, rw, mr, mc, fl;
  logic [4:0]  rs, rt, rd;
  logic        stall_o, pcw_o, ifid_o, bub_o, busy_o;
  logic [31:0] pend_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(
    .MUL_LAT  (4),
    .LOAD_LAT (1),
    .CNT_W    (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ID_valid_i      (valid),
    .ID_RSaddr_i     (rs),
    .ID_RTaddr_i     (rt),
    .ID_RDaddr_i     (rd),
    .ID_RegWrite_i   (rw),
    .ID_MemRead_i    (mr),
    .ID_MultiCycle_i (mc),
    .Flush_i         (fl),
    .Stall_o         (stall_o),
    .PCWrite_o       (pcw_o),
    .IF_ID_Write_o   (ifid_o),
    .ID_EX_Bubble_o  (bub_o),
    .MDU_Busy_o      (busy_o),
    .Pending_o       (pend_o)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mc;
    logic        fl;
    logic        stall;
    logic        busy;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                              logic w, logic m, logic c, logic f,
                              logic st, logic bz, logic [31:0] p);
    vec_t x;
    x.valid = v; x.rs = s; x.rt = t; x.rd = d;
    x.rw = w; x.mr = m; x.mc = c; x.fl = f;
    x.stall = st; x.busy = bz; x.pend = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    valid = x.valid; rs = x.rs; rt = x.rt; rd = x.rd;
    rw = x.rw; mr = x.mr; mc = x.mc; fl = x.fl;
  endtask

  task automatic check_outputs(input int idx, input logic exp_stall, input logic exp_fl,
                               input logic exp_busy, input logic [31:0] exp_pend);
    chk($sformatf("v%0d stall", idx), 32'(stall_o), 32'(exp_stall));
    chk($sformatf("v%0d pcwrite", idx), 32'(pcw_o), 32'(!exp_stall));
    chk($sformatf("v%0d ifid", idx), 32'(ifid_o), 32'(!exp_stall));
    chk($sformatf("v%0d bubble", idx), 32'(bub_o), 32'(exp_stall | exp_fl));
    chk($sformatf("v%0d busy", idx), 32'(busy_o), 32'(exp_busy));
    chk($sformatf("v%0d pending", idx), pend_o, exp_pend);
  endtask

  initial begin
    // Cycle-by-cycle table: expected values reflect state before the edge.
    //             v  rs  rt  rd  rw mr mc fl  stall busy pend
    vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 32'h0));      // idle
    vecs.push_back(mk(1, 1,  0,  8,  1, 1, 0, 0, 0, 0, 32'h0));      // lw r8
    vecs.push_back(mk(1, 8,  2,  9,  1, 0, 0, 0, 1, 0, 32'h100));    // add r9,r8,r2 stalls
    vecs.push_back(mk(1, 8,  2,  9,  1, 0, 0, 0, 0, 0, 32'h0));      // issues
    vecs.push_back(mk(1, 1,  0,  8,  1, 1, 0, 0, 0, 0, 32'h0));      // lw r8
    vecs.push_back(mk(1, 7,  2,  9,  1, 0, 0, 0, 0, 0, 32'h100));    // add r9,r7,r2 no stall
    vecs.push_back(mk(1, 1,  2,  3,  1, 0, 1, 0, 0, 0, 32'h0));      // mul r3
    vecs.push_back(mk(1, 3,  1,  4,  1, 0, 0, 0, 1, 1, 32'h8));      // add r4,r3,r1
    vecs.push_back(mk(1, 3,  1,  4,  1, 0, 0, 0, 1, 1, 32'h8));
    vecs.push_back(mk(1, 3,  1,  4,  1, 0, 0, 0, 1, 1, 32'h8));
    vecs.push_back(mk(1, 3,  1,  4,  1, 0, 0, 0, 1, 1, 32'h8));
    vecs.push_back(mk(1, 3,  1,  4,  1, 0, 0, 0, 0, 0, 32'h0));      // issues after 4 stalls
    vecs.push_back(mk(1, 1,  2,  3,  1, 0, 1, 0, 0, 0, 32'h0));      // mul r3
    vecs.push_back(mk(1, 1,  2,  6,  1, 0, 1, 0, 1, 1, 32'h8));      // mul r6: structural
    vecs.push_back(mk(1, 1,  2,  6,  1, 0, 1, 0, 1, 1, 32'h8));
    vecs.push_back(mk(1, 1,  2,  6,  1, 0, 1, 0, 1, 1, 32'h8));
    vecs.push_back(mk(1, 1,  2,  6,  1, 0, 1, 0, 0, 1, 32'h8));      // issues in final MDU cycle
    vecs.push_back(mk(1, 1,  0,  6,  1, 1, 0, 0, 1, 1, 32'h40));     // lw r6: WAW, cnt6=4
    vecs.push_back(mk(1, 1,  0,  6,  1, 1, 0, 0, 1, 1, 32'h40));     // cnt6=3
    vecs.push_back(mk(1, 1,  0,  6,  1, 1, 0, 0, 1, 1, 32'h40));     // cnt6=2
    vecs.push_back(mk(1, 1,  0,  6,  1, 1, 0, 0, 0, 1, 32'h40));     // cnt6=1 -> issues, set wins
    vecs.push_back(mk(1, 6,  0,  7,  1, 0, 0, 0, 1, 0, 32'h40));     // consumer stalls once
    vecs.push_back(mk(1, 6,  0,  7,  1, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1,  0,  0,  1, 1, 0, 0, 0, 0, 32'h0));      // lw r0
    vecs.push_back(mk(1, 0,  0,  1,  1, 0, 0, 0, 0, 0, 32'h0));      // add r1,r0,r0
    vecs.push_back(mk(1, 1,  0,  8,  1, 1, 0, 0, 0, 0, 32'h0));      // lw r8
    vecs.push_back(mk(1, 8,  2,  5,  1, 0, 1, 1, 0, 0, 32'h100));    // flushed dependent mul
    vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 32'h0));      // nothing was set
    vecs.push_back(mk(1, 1,  0,  5,  1, 1, 0, 0, 0, 0, 32'h0));      // lw r5
    vecs.push_back(mk(1, 1,  0,  5,  1, 1, 0, 0, 0, 0, 32'h20));     // lw r5 while cnt5=1
    vecs.push_back(mk(1, 5,  2,  9,  1, 0, 0, 0, 1, 0, 32'h20));     // cnt5 reloaded to 1
    vecs.push_back(mk(1, 5,  2,  9,  1, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 10, 0,  10, 1, 1, 0, 0, 0, 0, 32'h0));      // lw r10,(r10)
    vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 32'h400));
    vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 32'h0));

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    rst_i = 1'b0;
    #2;
    check_outputs(-1, 1'b0, 1'b0, 1'b0, 32'h0);
    fl = 1'b1;
    #1;
    chk("reset bubble follows flush", 32'(bub_o), 32'd1);
    fl = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outputs(i, vecs[i].stall, vecs[i].fl, vecs[i].busy, vecs[i].pend);
      @(posedge clk);
      #1;
    end

    // Reset mid-stall with cnt[5]=3.
    drive(mk(1, 1, 2, 5, 1, 0, 1, 0, 0, 0, 32'h0));               // mul r5
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    drive(mk(1, 5, 0, 9, 1, 0, 0, 0, 0, 0, 32'h0));               // add r9,r5,r0
    #1;
    chk("pre-reset stall", 32'(stall_o), 32'd1);
    chk("pre-reset pending", pend_o, 32'h20);
    chk("pre-reset busy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("reset stall drop", 32'(stall_o), 32'd0);
    chk("reset pcwrite", 32'(pcw_o), 32'd1);
    chk("reset pending", pend_o, 32'h0);
    chk("reset busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset r5 reader stall", 32'(stall_o), 32'd0);
    chk("post-reset bubble", 32'(bub_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
